// File: rtl/perf_sys_pkg.sv
// perf_sys shared definitions.
// Run-controller state and fail-cause encodings, default limits.
package perf_sys_pkg;

    typedef logic [2:0] run_state_t;
    typedef logic [1:0] fail_cause_t;

    localparam run_state_t ST_IDLE = 3'd0;
    localparam run_state_t ST_RUN  = 3'd1;
    localparam run_state_t ST_HOLD = 3'd2;
    localparam run_state_t ST_DONE = 3'd3;
    localparam run_state_t ST_FAIL = 3'd4;

    localparam fail_cause_t CAUSE_NONE  = 2'b00;
    localparam fail_cause_t CAUSE_OVF   = 2'b01;
    localparam fail_cause_t CAUSE_STALL = 2'b10;

    localparam int DEF_LOOP_LIMIT   = 5000;
    localparam int DEF_STALL_CYCLES = 255;
    localparam int DEF_WIDTH        = 16;

    // Bits needed to hold 0..cycles without wrapping.
    function automatic int stall_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/loop_stall_timer.sv
// Saturating cycle counter with clear and enable.
// expired flags the enabled cycle that takes the count to CYCLES.
module loop_stall_timer
    import perf_sys_pkg::*;
#(
    parameter int CYCLES = DEF_STALL_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = stall_width(CYCLES);
    localparam logic [W-1:0] LIM  = W'(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count_q;

    // Count enabled cycles; clear wins, saturate at CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIM)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Combinational look-ahead so the owner can react on the same edge.
    always_comb begin
        expired = enable && !clear && (count_q == LAST);
    end

endmodule

// File: rtl/loop_run_ctrl.sv
// Run controller for the perf_sys loop-limit datapath.
// Counts steps against a limit, watches for stalls, holds result until ack.
module loop_run_ctrl
    import perf_sys_pkg::*;
#(
    parameter int LOOP_LIMIT   = DEF_LOOP_LIMIT,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int WIDTH        = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             hold,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_cause,
    output logic [WIDTH-1:0] loop_count,
    output logic [2:0]       state
);

    localparam logic [WIDTH-1:0] DEF_LIM = WIDTH'(LOOP_LIMIT);

    run_state_t       state_q, state_n;
    fail_cause_t      cause_q, cause_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] limit_q, limit_n;
    logic             busy_q, done_q, fail_q;

    logic stall_clr;
    logic stall_en;
    logic stall_exp;
    logic at_limit;

    // Stall timer restarts at start and on every counted step;
    // it only advances in RUN on cycles with no step and no hold.
    always_comb begin
        stall_clr = ((state_q == ST_IDLE) && start)
                 || ((state_q == ST_RUN) && step);
        stall_en  = (state_q == ST_RUN) && !step && !hold;
        at_limit  = (count_q == limit_q);
    end

    loop_stall_timer #(
        .CYCLES (STALL_CYCLES)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .clear   (stall_clr),
        .enable  (stall_en),
        .expired (stall_exp)
    );

    // Next-state, counter and limit selection.
    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        count_n = count_q;
        limit_n = limit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    limit_n = (cfg_limit == '0) ? DEF_LIM : cfg_limit;
                end
                if (start) begin
                    state_n = ST_RUN;
                    count_n = '0;
                end
            end
            ST_RUN: begin
                if (step && at_limit) begin
                    state_n = ST_FAIL;
                    cause_n = CAUSE_OVF;
                end else begin
                    if (step) begin
                        count_n = count_q + 1'b1;
                    end
                    if (stop) begin
                        state_n = ST_DONE;
                    end else if (hold) begin
                        state_n = ST_HOLD;
                    end else if (stall_exp) begin
                        state_n = ST_FAIL;
                        cause_n = CAUSE_STALL;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_n = ST_DONE;
                end else if (!hold) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (ack) begin
                    state_n = ST_IDLE;
                    cause_n = CAUSE_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cause_n = CAUSE_NONE;
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            count_q <= '0;
            limit_q <= DEF_LIM;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            count_q <= count_n;
            limit_q <= limit_n;
            busy_q  <= (state_n == ST_RUN) || (state_n == ST_HOLD);
            done_q  <= (state_n == ST_DONE);
            fail_q  <= (state_n == ST_FAIL);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_cause = cause_q;
    assign loop_count = count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_loop_run_ctrl.sv
// Self-checking bench for loop_run_ctrl.
// Directed scenarios plus randomized runs against an outcome model.
module tb_loop_run_ctrl;

    localparam int STALL = 8;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [W-1:0] cfg_limit;
    logic         start, step, stop, hold, ack;
    logic         busy, done, fail;
    logic [1:0]   fail_cause;
    logic [W-1:0] loop_count;
    logic [2:0]   state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    loop_run_ctrl #(
        .LOOP_LIMIT   (5000),
        .STALL_CYCLES (STALL),
        .WIDTH        (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_limit  (cfg_limit),
        .start      (start),
        .step       (step),
        .stop       (stop),
        .hold       (hold),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_cause (fail_cause),
        .loop_count (loop_count),
        .state      (state)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cfg_we = 0; cfg_limit = '0; start = 0;
        step = 0; stop = 0; hold = 0; ack = 0;
    endtask

    task automatic do_ack();
        ack = 1; cyc(); ack = 0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1;
        start = 1; step = 1;
        cyc(); cyc();
        quiet();
        reset = 0;
        cyc();
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state got %0d want 0", state);
        end
        n_checks++;
        if ({busy, done, fail} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, fail});
        end
        n_checks++;
        if (fail_cause !== 2'b00 || loop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got cause=%0d cnt=%0d want 0/0", fail_cause, loop_count);
        end
    endtask

    task automatic test_normal();
        cfg_we = 1; cfg_limit = 16'd10; cyc(); quiet();
        start = 1; cyc(); start = 0;
        n_checks++;
        if (busy !== 1'b1 || state !== 3'd1) begin
            n_fail++; $display("FAIL normal_start got busy=%b st=%0d want 1/1", busy, state);
        end
        step = 1;
        repeat (7) cyc();
        step = 0;
        n_checks++;
        if (loop_count !== 16'd7) begin
            n_fail++; $display("FAIL normal_count got %0d want 7", loop_count);
        end
        stop = 1; cyc(); stop = 0;
        n_checks++;
        if (done !== 1'b1 || fail_cause !== 2'b00 || state !== 3'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_done got done=%b cause=%0d st=%0d busy=%b want 1/0/3/0",
                     done, fail_cause, state, busy);
        end
        do_ack();
        n_checks++;
        if (state !== 3'd0 || done !== 1'b0 || loop_count !== 16'd7) begin
            n_fail++;
            $display("FAIL normal_ack got st=%0d done=%b cnt=%0d want 0/0/7",
                     state, done, loop_count);
        end
    endtask

    task automatic test_overflow();
        cfg_we = 1; cfg_limit = 16'd3; start = 1; cyc(); quiet();
        step = 1;
        repeat (3) cyc();
        n_checks++;
        if (state !== 3'd1 || loop_count !== 16'd3 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pre got st=%0d cnt=%0d fail=%b want 1/3/0", state, loop_count, fail);
        end
        cyc();
        n_checks++;
        if (fail !== 1'b1 || fail_cause !== 2'b01 || loop_count !== 16'd3 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_fail got fail=%b cause=%0d cnt=%0d st=%0d want 1/1/3/4",
                     fail, fail_cause, loop_count, state);
        end
        repeat (2) cyc();
        step = 0;
        start = 1; cyc(); start = 0;
        n_checks++;
        if (loop_count !== 16'd3 || state !== 3'd4 || fail_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_hold got cnt=%0d st=%0d cause=%0d want 3/4/1",
                     loop_count, state, fail_cause);
        end
        do_ack();
        n_checks++;
        if (fail !== 1'b0 || fail_cause !== 2'b00 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL ovf_ack got fail=%b cause=%0d st=%0d want 0/0/0", fail, fail_cause, state);
        end
    endtask

    task automatic test_stall();
        start = 1; cyc(); start = 0;
        repeat (STALL - 1) cyc();
        n_checks++;
        if (state !== 3'd1 || fail !== 1'b0) begin
            n_fail++; $display("FAIL stall_early got st=%0d fail=%b want 1/0", state, fail);
        end
        cyc();
        n_checks++;
        if (fail !== 1'b1 || fail_cause !== 2'b10 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL stall_fail got fail=%b cause=%0d st=%0d want 1/2/4", fail, fail_cause, state);
        end
        do_ack();
        start = 1; cyc(); start = 0;
        repeat (5) cyc();
        hold = 1;
        cyc();
        n_checks++;
        if (state !== 3'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL hold_enter got st=%0d busy=%b want 2/1", state, busy);
        end
        repeat (19) cyc();
        hold = 0;
        cyc();
        repeat (2) cyc();
        n_checks++;
        if (state !== 3'd1 || fail !== 1'b0) begin
            n_fail++; $display("FAIL hold_nostall got st=%0d fail=%b want 1/0", state, fail);
        end
        step = 1; cyc(); step = 0;
        stop = 1; cyc(); stop = 0;
        n_checks++;
        if (done !== 1'b1 || loop_count !== 16'd1) begin
            n_fail++; $display("FAIL hold_done got done=%b cnt=%0d want 1/1", done, loop_count);
        end
        do_ack();
        start = 1; cyc(); start = 0;
        hold = 1; cyc();
        stop = 1; cyc(); stop = 0; hold = 0;
        n_checks++;
        if (state !== 3'd3 || done !== 1'b1) begin
            n_fail++; $display("FAIL hold_stop got st=%0d done=%b want 3/1", state, done);
        end
        do_ack();
    endtask

    task automatic test_simultaneous();
        cfg_we = 1; cfg_limit = 16'd5; start = 1; cyc(); quiet();
        step = 1; repeat (4) cyc();
        stop = 1; cyc(); quiet();
        n_checks++;
        if (state !== 3'd3 || loop_count !== 16'd5 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_done got st=%0d cnt=%0d done=%b want 3/5/1", state, loop_count, done);
        end
        do_ack();
        start = 1; cyc(); start = 0;
        step = 1; repeat (5) cyc();
        stop = 1; cyc(); quiet();
        n_checks++;
        if (state !== 3'd4 || fail_cause !== 2'b01 || loop_count !== 16'd5 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_ovf got st=%0d cause=%0d cnt=%0d done=%b want 4/1/5/0",
                     state, fail_cause, loop_count, done);
        end
        do_ack();
    endtask

    task automatic test_ignored();
        cfg_we = 1; cfg_limit = 16'd10; start = 1; cyc(); quiet();
        cfg_we = 1; cfg_limit = 16'd2; start = 1; cyc(); quiet();
        step = 1; repeat (5) cyc(); step = 0;
        n_checks++;
        if (state !== 3'd1 || loop_count !== 16'd5) begin
            n_fail++; $display("FAIL ign_cfg got st=%0d cnt=%0d want 1/5", state, loop_count);
        end
        stop = 1; cyc(); stop = 0;
        start = 1; cyc(); cyc(); start = 0;
        n_checks++;
        if (state !== 3'd3 || loop_count !== 16'd5) begin
            n_fail++; $display("FAIL ign_start got st=%0d cnt=%0d want 3/5", state, loop_count);
        end
        do_ack();
        cfg_we = 1; cfg_limit = 16'd3; cyc(); quiet();
        cfg_we = 1; cfg_limit = 16'd0; start = 1; cyc(); quiet();
        step = 1; repeat (100) cyc(); step = 0;
        stop = 1; cyc(); stop = 0;
        n_checks++;
        if (state !== 3'd3 || loop_count !== 16'd100) begin
            n_fail++; $display("FAIL cfg_zero got st=%0d cnt=%0d want 3/100", state, loop_count);
        end
        do_ack();
    endtask

    task automatic test_reset_midrun();
        cfg_we = 1; cfg_limit = 16'd50; start = 1; cyc(); quiet();
        step = 1; repeat (42) cyc(); step = 0;
        n_checks++;
        if (loop_count !== 16'd42) begin
            n_fail++; $display("FAIL rst_pre got cnt=%0d want 42", loop_count);
        end
        reset = 1; cyc(); reset = 0;
        n_checks++;
        if (state !== 3'd0 || loop_count !== 16'd0 || {busy, done, fail} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid got st=%0d cnt=%0d flags=%b want 0/0/000",
                     state, loop_count, {busy, done, fail});
        end
        start = 1; cyc(); start = 0;
        step = 1; repeat (5000) cyc();
        n_checks++;
        if (state !== 3'd1 || loop_count !== 16'd5000) begin
            n_fail++; $display("FAIL rst_lim got st=%0d cnt=%0d want 1/5000", state, loop_count);
        end
        cyc(); step = 0;
        n_checks++;
        if (state !== 3'd4 || fail_cause !== 2'b01 || loop_count !== 16'd5000) begin
            n_fail++;
            $display("FAIL rst_ovf got st=%0d cause=%0d cnt=%0d want 4/1/5000",
                     state, fail_cause, loop_count);
        end
        do_ack();
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int lim, n, gs, cnt;
            int gaps[$];
            logic [2:0] exp_st;
            logic [1:0] exp_cause;
            lim = $urandom_range(1, 12);
            n   = $urandom_range(0, 15);
            gs  = $urandom_range(0, 5);
            gaps.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 11) == 0)
                    gaps.push_back(STALL + $urandom_range(0, 2));
                else
                    gaps.push_back($urandom_range(0, 5));
            end
            cnt = 0; exp_st = 3'd3; exp_cause = 2'b00;
            foreach (gaps[i]) begin
                if (gaps[i] >= STALL) begin
                    exp_st = 3'd4; exp_cause = 2'b10; break;
                end
                if (cnt == lim) begin
                    exp_st = 3'd4; exp_cause = 2'b01; break;
                end
                cnt++;
            end
            cfg_we = 1; cfg_limit = W'(lim); start = 1; cyc(); quiet();
            foreach (gaps[i]) begin
                repeat (gaps[i]) cyc();
                step = 1; cyc(); step = 0;
            end
            repeat (gs) cyc();
            stop = 1; cyc(); stop = 0;
            n_checks++;
            if (state !== exp_st || fail_cause !== exp_cause) begin
                n_fail++;
                $display("FAIL rand%0d_end got st=%0d cause=%0d want %0d/%0d",
                         r, state, fail_cause, exp_st, exp_cause);
            end
            n_checks++;
            if (loop_count !== W'(cnt)) begin
                n_fail++; $display("FAIL rand%0d_cnt got %0d want %0d", r, loop_count, cnt);
            end
            do_ack();
        end
    endtask

    initial begin
        quiet();
        reset = 1;
        test_reset();
        test_normal();
        test_overflow();
        test_stall();
        test_simultaneous();
        test_ignored();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
